// File: rtl/dwt_2d_fwd_if.sv
// Row-stream interface for the 8x8 Haar forward DWT.
//   in_valid/in_ready/in_row      : pixel rows into the block (8 x u8)
//   out_valid/out_ready/out_row   : coefficient rows out of the block (8 x s16)
//   out_last                      : marks the 8th output row of a block
// slave  : the transform block
// master : the producer/consumer driving it
interface dwt_2d_fwd_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_row;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_row;
  logic         out_last;

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_last
  );

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_last
  );
endinterface

// File: rtl/dwt_2d_fwd.sv
// One-level lossless integer Haar forward 2D DWT over an 8x8 pixel block.
// Rows are loaded one per transfer; the horizontal pass (pair sums/differences)
// is applied on the way into the buffer, the vertical pass on the way out.
// Output row k (0..3) is the vertical sum of buffer rows 2k/2k+1, row k+4 the
// matching difference, so row k pairs with row k+4 for the inverse transform.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dwt_2d_fwd_if.slave (row input stream, coefficient output stream)
module dwt_2d_fwd (
  input  logic          clk,
  input  logic          rst_n,
  dwt_2d_fwd_if.slave   bus
);

  typedef enum logic [0:0] {StLoad, StOut} state_e;

  state_e            r_state;
  logic [2:0]        r_row;
  logic [2:0]        r_k;
  logic signed [9:0] r_buf [8][8];

  logic              w_in_fire;
  logic              w_out_fire;
  logic signed [9:0] w_even [4];
  logic signed [9:0] w_odd  [4];
  logic signed [9:0] w_coef [8];
  logic [2:0]        w_ia;
  logic [2:0]        w_ib;
  logic signed [10:0] w_a   [8];
  logic signed [10:0] w_b   [8];
  logic signed [10:0] w_res [8];

  assign bus.in_ready  = (r_state == StLoad);
  assign bus.out_valid = (r_state == StOut);
  assign bus.out_last  = (r_state == StOut) && (r_k == 3'd7);

  assign w_in_fire  = bus.in_valid && (r_state == StLoad);
  assign w_out_fire = bus.out_ready && (r_state == StOut);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StLoad;
      r_row   <= 3'd0;
      r_k     <= 3'd0;
    end else begin
      unique case (r_state)
        StLoad: begin
          if (w_in_fire) begin
            r_row <= r_row + 3'd1;  // wraps to 0 after row 7
            if (r_row == 3'd7) r_state <= StOut;
          end
        end
        StOut: begin
          if (w_out_fire) begin
            r_k <= r_k + 3'd1;      // wraps to 0 after row 7
            if (r_k == 3'd7) r_state <= StLoad;
          end
        end
        default: r_state <= StLoad;
      endcase
    end
  end

  // Horizontal pass: low-pass in columns 0..3, high-pass in 4..7.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_even[j]     = {2'b00, bus.in_row[16*j +: 8]};
      w_odd[j]      = {2'b00, bus.in_row[16*j+8 +: 8]};
      w_coef[j]     = w_even[j] + w_odd[j];
      w_coef[4+j]   = w_even[j] - w_odd[j];
    end
  end

  // Data buffer needs no reset; stale contents are never observable.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      for (int j = 0; j < 8; j++) begin
        r_buf[r_row][j] <= w_coef[j];
      end
    end
  end

  // Vertical pass on the row pair selected by k; k[2] picks sum vs difference.
  assign w_ia = {r_k[1:0], 1'b0};
  assign w_ib = {r_k[1:0], 1'b1};

  always_comb begin
    bus.out_row = '0;
    for (int e = 0; e < 8; e++) begin
      w_a[e]   = {r_buf[w_ia][e][9], r_buf[w_ia][e]};
      w_b[e]   = {r_buf[w_ib][e][9], r_buf[w_ib][e]};
      w_res[e] = r_k[2] ? (w_a[e] - w_b[e]) : (w_a[e] + w_b[e]);
      if (r_state == StOut) begin
        bus.out_row[16*e +: 16] = {{5{w_res[e][10]}}, w_res[e]};
      end
    end
  end

endmodule

// File: tb/tb_dwt_2d_fwd.sv
module tb_dwt_2d_fwd;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dwt_2d_fwd_if bus ();

  dwt_2d_fwd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int pix [8][8];
  logic [127:0] got [8];

  // Reference: 2x2 Haar directly from the pixel block, signs chosen by quadrant.
  function automatic int ref_coef(int k, int e);
    int r0, r1, c0, c1, sh, sv;
    r0 = 2 * (k % 4);
    r1 = r0 + 1;
    c0 = 2 * (e % 4);
    c1 = c0 + 1;
    sh = (e < 4) ? 1 : -1;
    sv = (k < 4) ? 1 : -1;
    return (pix[r0][c0] + sh * pix[r0][c1]) + sv * (pix[r1][c0] + sh * pix[r1][c1]);
  endfunction

  function automatic logic [127:0] ref_row(int k);
    logic [127:0] v;
    int c;
    v = '0;
    for (int e = 0; e < 8; e++) begin
      c = ref_coef(k, e);
      v[16*e +: 16] = 16'(c);
    end
    return v;
  endfunction

  function automatic logic [63:0] pack_row(int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[8*c +: 8] = 8'(pix[r][c]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (mode)
          0: pix[r][c] = 8'h10;
          1: pix[r][c] = 0;
          2: pix[r][c] = 8'hFF;
          default: pix[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  // Entered and left at a negedge.
  task automatic send_rows(input int n, input bit gaps);
    int acc = 0;
    int guard = 0;
    bit fire;
    while (acc < n && guard < 200) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_row   = {$urandom, $urandom};
      end else begin
        bus.in_valid = 1'b1;
        bus.in_row   = pack_row(acc);
      end
      fire = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (fire) acc++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_row   = {$urandom, $urandom};
    if (acc < n) begin
      checks++;
      failures++;
      $error("FAIL send_timeout observed=%0d rows expected=%0d rows", acc, n);
    end else if (n == 8) begin
      check("latency_out_valid", bus.out_valid, 1'b1);
      check("latency_in_ready", bus.in_ready, 1'b0);
    end
  endtask

  task automatic recv_block(input bit stalls);
    int k = 0;
    int guard = 0;
    while (k < 8 && guard < 300) begin
      bus.out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        got[k] = bus.out_row;
        check($sformatf("row%0d", k), bus.out_row, ref_row(k));
        check($sformatf("last%0d", k), bus.out_last, (k == 7));
        k++;
      end
      @(negedge clk);
      guard++;
    end
    bus.out_ready = 1'b0;
    if (k < 8) begin
      checks++;
      failures++;
      $error("FAIL recv_timeout observed=%0d rows expected=8 rows", k);
    end else begin
      check("back_to_load_in_ready", bus.in_ready, 1'b1);
      check("back_to_load_out_valid", bus.out_valid, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_last"}, bus.out_last, 1'b0);
    check({tag, "_out_row"}, bus.out_row, 128'h0);
  endtask

  logic [127:0] held;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b1;  // ignored while loading
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Flat block of 0x10.
    fill(0);
    send_rows(8, 1'b0);
    recv_block(1'b0);
    check("flat_ll", got[0][15:0], 16'h0040);
    check("flat_lh", got[4][15:0], 16'h0000);

    // Single impulse at (0,0).
    fill(1);
    pix[0][0] = 255;
    send_rows(8, 1'b0);
    recv_block(1'b0);
    check("imp00_r4e4", got[4][79:64], 16'h00FF);

    // Single impulse at (0,1): negative high-pass terms.
    fill(1);
    pix[0][1] = 255;
    send_rows(8, 1'b1);
    recv_block(1'b0);
    check("imp01_r0e4", got[0][79:64], 16'hFF01);
    check("imp01_r4e4", got[4][79:64], 16'hFF01);

    // Full-scale block.
    fill(2);
    send_rows(8, 1'b0);
    recv_block(1'b1);
    check("max_r3e3", got[3][63:48], 16'h03FC);

    // Backpressure: hold out_ready low 5 cycles with stray in_valid pulses.
    fill(3);
    send_rows(8, 1'b0);
    bus.out_ready = 1'b0;
    held = bus.out_row;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = $urandom_range(0, 1);
      bus.in_row   = {$urandom, $urandom};
      @(negedge clk);
      check($sformatf("stall_row_%0d", i), bus.out_row, held);
      check($sformatf("stall_in_ready_%0d", i), bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    recv_block(1'b0);

    // Reset in the middle of a load, then a fresh block.
    fill(3);
    send_rows(5, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    @(negedge clk);
    fill(3);
    send_rows(8, 1'b1);
    recv_block(1'b1);

    // Reset in the middle of output.
    fill(3);
    send_rows(8, 1'b0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("outreset");
    rst_n = 1'b1;
    @(negedge clk);

    // Random blocks with input gaps and output stalls.
    for (int b = 0; b < 4; b++) begin
      fill(3);
      send_rows(8, 1'b1);
      recv_block(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
